// File: rtl/pipe_stage_latch_if.sv
// Stage-to-stage bundle for pipe_stage_latch: upstream payload and controls in,
// final-slice payload and stall statistics out.
interface pipe_stage_latch_if #(
  parameter int INSN_W = 32,
  parameter int PC_W   = 12,
  parameter int CNT_W  = 16
);
  logic [INSN_W-1:0] i_insn;
  logic [PC_W-1:0]   i_PC_plus;
  logic              i_valid;
  logic              i_stall;
  logic              i_flush;
  logic [INSN_W-1:0] o_insn;
  logic [PC_W-1:0]   o_PC_plus;
  logic              o_valid;
  logic [CNT_W-1:0]  o_stall_count;

  modport master (
    output i_insn, i_PC_plus, i_valid, i_stall, i_flush,
    input  o_insn, o_PC_plus, o_valid, o_stall_count
  );

  modport slave (
    input  i_insn, i_PC_plus, i_valid, i_stall, i_flush,
    output o_insn, o_PC_plus, o_valid, o_stall_count
  );
endinterface

// File: rtl/pipe_stage_latch.sv
// Falling-edge inter-stage pipeline register of DEPTH slices with stall hold,
// flush-to-NOP bubble injection and a saturating stall-cycle counter.
module pipe_stage_latch #(
  parameter int                INSN_W = 32,
  parameter int                PC_W   = 12,
  parameter int                DEPTH  = 1,
  parameter logic [INSN_W-1:0] NOP    = {INSN_W{1'b0}},
  parameter int                CNT_W  = 16
) (
  input logic               clock,
  input logic               reset,
  pipe_stage_latch_if.slave bus
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_latch: DEPTH must be within 1..4");
  end

  logic [INSN_W-1:0] insn_q  [DEPTH];
  logic [INSN_W-1:0] insn_d  [DEPTH];
  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [PC_W-1:0]   pc_d    [DEPTH];
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  // Slice next-state: flush beats stall beats normal shift.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      insn_d[k]  = insn_q[k];
      pc_d[k]    = pc_q[k];
      valid_d[k] = valid_q[k];
    end
    if (bus.i_flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        insn_d[k]  = NOP;
        pc_d[k]    = {PC_W{1'b0}};
        valid_d[k] = 1'b0;
      end
    end else if (bus.i_stall) begin
      for (int k = 0; k < DEPTH; k++) begin
        insn_d[k]  = insn_q[k];
        pc_d[k]    = pc_q[k];
        valid_d[k] = valid_q[k];
      end
    end else begin
      insn_d[0]  = bus.i_insn;
      pc_d[0]    = bus.i_PC_plus;
      valid_d[0] = bus.i_valid;
      for (int k = 1; k < DEPTH; k++) begin
        insn_d[k]  = insn_q[k-1];
        pc_d[k]    = pc_q[k-1];
        valid_d[k] = valid_q[k-1];
      end
    end
  end

  // Stall counter next-state; a flushed cycle never counts as a stall.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_stall && !bus.i_flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers, captured on the falling edge.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        insn_q[k]  <= NOP;
        pc_q[k]    <= {PC_W{1'b0}};
        valid_q[k] <= 1'b0;
      end
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        insn_q[k]  <= insn_d[k];
        pc_q[k]    <= pc_d[k];
        valid_q[k] <= valid_d[k];
      end
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_insn        = insn_q[DEPTH-1];
  assign bus.o_PC_plus     = pc_q[DEPTH-1];
  assign bus.o_valid       = valid_q[DEPTH-1];
  assign bus.o_stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Directed bench for pipe_stage_latch across four configurations sharing one
// clock and reset: default, DEPTH=3, CNT_W=4, and a 64/20-bit wide variant.
module tb_pipe_stage_latch;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pipe_stage_latch_if #(.INSN_W(32), .PC_W(12), .CNT_W(16)) ifa ();
  pipe_stage_latch_if #(.INSN_W(32), .PC_W(12), .CNT_W(16)) ifb ();
  pipe_stage_latch_if #(.INSN_W(32), .PC_W(12), .CNT_W(4))  ifc ();
  pipe_stage_latch_if #(.INSN_W(64), .PC_W(20), .CNT_W(16)) ifd ();

  pipe_stage_latch #(.INSN_W(32), .PC_W(12), .DEPTH(1), .NOP(32'h0), .CNT_W(16))
    dut_a (.clock(clk), .reset(rst), .bus(ifa));
  pipe_stage_latch #(.INSN_W(32), .PC_W(12), .DEPTH(3), .NOP(32'h0), .CNT_W(16))
    dut_b (.clock(clk), .reset(rst), .bus(ifb));
  pipe_stage_latch #(.INSN_W(32), .PC_W(12), .DEPTH(1), .NOP(32'h0), .CNT_W(4))
    dut_c (.clock(clk), .reset(rst), .bus(ifc));
  pipe_stage_latch #(.INSN_W(64), .PC_W(20), .DEPTH(1), .NOP(64'h13), .CNT_W(16))
    dut_d (.clock(clk), .reset(rst), .bus(ifd));

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one falling edge and settle away from it.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    ifa.i_insn = 32'h0; ifa.i_PC_plus = 12'h0; ifa.i_valid = 1'b0; ifa.i_stall = 1'b0; ifa.i_flush = 1'b0;
    ifb.i_insn = 32'h0; ifb.i_PC_plus = 12'h0; ifb.i_valid = 1'b0; ifb.i_stall = 1'b0; ifb.i_flush = 1'b0;
    ifc.i_insn = 32'h0; ifc.i_PC_plus = 12'h0; ifc.i_valid = 1'b0; ifc.i_stall = 1'b0; ifc.i_flush = 1'b0;
    ifd.i_insn = 64'h0; ifd.i_PC_plus = 20'h0; ifd.i_valid = 1'b0; ifd.i_stall = 1'b0; ifd.i_flush = 1'b0;
    tick();
    tick();
    check_eq("rst_d_insn", ifd.o_insn, 64'h13);
    rst = 1'b0;

    // Reset mid-cycle with a live payload in the slice.
    ifa.i_insn = 32'h1234_5678; ifa.i_PC_plus = 12'h123; ifa.i_valid = 1'b1;
    tick();
    check_eq("pre_rst_insn", ifa.o_insn, 64'h1234_5678);
    #1 rst = 1'b1;
    #1;
    check_eq("async_rst_insn", ifa.o_insn, 64'h0);
    check_eq("async_rst_pc", ifa.o_PC_plus, 64'h0);
    check_eq("async_rst_valid", ifa.o_valid, 64'h0);
    check_eq("async_rst_cnt", ifa.o_stall_count, 64'h0);
    ifa.i_insn = 32'h3333; ifa.i_stall = 1'b1;
    tick();
    check_eq("held_rst_insn", ifa.o_insn, 64'h0);
    check_eq("held_rst_cnt", ifa.o_stall_count, 64'h0);
    rst = 1'b0;
    ifa.i_stall = 1'b0; ifa.i_insn = 32'hA; ifa.i_PC_plus = 12'h005; ifa.i_valid = 1'b1;
    tick();
    check_eq("post_rst_insn", ifa.o_insn, 64'hA);
    check_eq("post_rst_pc", ifa.o_PC_plus, 64'h005);
    check_eq("post_rst_valid", ifa.o_valid, 64'h1);

    // Invalid slot still carries its payload.
    ifa.i_insn = 32'h55; ifa.i_PC_plus = 12'h003; ifa.i_valid = 1'b0;
    tick();
    check_eq("inv_insn", ifa.o_insn, 64'h55);
    check_eq("inv_pc", ifa.o_PC_plus, 64'h003);
    check_eq("inv_valid", ifa.o_valid, 64'h0);

    // Stall holds the slice for five edges while the input changes.
    ifa.i_insn = 32'h11; ifa.i_valid = 1'b1;
    tick();
    check_eq("stall_load", ifa.o_insn, 64'h11);
    ifa.i_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifa.i_insn = 32'h20 + 32'(i);
      tick();
      check_eq("stall_hold", ifa.o_insn, 64'h11);
    end
    check_eq("stall_cnt5", ifa.o_stall_count, 64'd5);
    ifa.i_stall = 1'b0; ifa.i_insn = 32'h77;
    tick();
    check_eq("stall_release", ifa.o_insn, 64'h77);
    check_eq("stall_cnt_hold", ifa.o_stall_count, 64'd5);

    // Flush wins over a simultaneous stall and is not counted.
    ifa.i_stall = 1'b1; ifa.i_flush = 1'b1;
    tick();
    check_eq("flush_insn", ifa.o_insn, 64'h0);
    check_eq("flush_pc", ifa.o_PC_plus, 64'h0);
    check_eq("flush_valid", ifa.o_valid, 64'h0);
    check_eq("flush_cnt", ifa.o_stall_count, 64'd5);
    ifa.i_stall = 1'b0; ifa.i_flush = 1'b0;

    // DEPTH=3 latency: inputs 1..4 then idle.
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) begin
        ifb.i_insn = 32'(i); ifb.i_PC_plus = 12'(i); ifb.i_valid = 1'b1;
      end else begin
        ifb.i_insn = 32'h0; ifb.i_PC_plus = 12'h0; ifb.i_valid = 1'b0;
      end
      tick();
      check_eq("lat_insn", ifb.o_insn, (i < 3) ? 64'h0 : 64'(i - 2));
      check_eq("lat_valid", ifb.o_valid, (i < 3) ? 64'h0 : 64'h1);
    end
    check_eq("lat_pc", ifb.o_PC_plus, 64'h4);

    // Counter saturation at 15 with CNT_W=4.
    ifc.i_stall = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check_eq("sat_cnt14", ifc.o_stall_count, 64'd14);
      if (i >= 15) check_eq("sat_cnt15", ifc.o_stall_count, 64'd15);
    end
    ifc.i_stall = 1'b0;

    // Wide variant: flush to custom NOP, then full-width payload.
    ifd.i_insn = 64'hFFFF_FFFF_FFFF_FFFF; ifd.i_PC_plus = 20'h12345; ifd.i_valid = 1'b1;
    tick();
    ifd.i_flush = 1'b1;
    tick();
    check_eq("wide_flush_insn", ifd.o_insn, 64'h13);
    check_eq("wide_flush_pc", ifd.o_PC_plus, 64'h0);
    check_eq("wide_flush_valid", ifd.o_valid, 64'h0);
    ifd.i_flush = 1'b0;
    ifd.i_insn = 64'hDEAD_BEEF_0000_0001; ifd.i_PC_plus = 20'hFFFFF; ifd.i_valid = 1'b1;
    tick();
    check_eq("wide_insn", ifd.o_insn, 64'hDEAD_BEEF_0000_0001);
    check_eq("wide_pc", ifd.o_PC_plus, 64'hFFFFF);
    check_eq("wide_valid", ifd.o_valid, 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_latch.md
Name: pipe_stage_latch

Overview:
Parametrised inter-stage pipeline register, the successor to the fixed 32-bit insn / 12-bit PC F/D latch. It carries instruction, PC+1 and a valid bit through DEPTH register slices. It adds stall (hold), flush (NOP/bubble injection) and a saturating stall-cycle counter for performance monitoring. It is instantiated between F/D, D/X, X/M and M/W in the five-stage processor.

Parameters:
INSN_W, 32, instruction width in bits
PC_W, 12, PC+1 field width in bits
DEPTH, 1, number of cascaded register slices (legal 1..4)
NOP, 32'h0000_0000, instruction value injected on flush/reset (INSN_W bits)
CNT_W, 16, stall counter width

Ports:
clock  in  1  stage clock; all state updates on the falling edge
reset  in  1  asynchronous, active-high reset
i_insn  in  INSN_W  instruction from upstream stage
i_PC_plus  in  PC_W  PC+1 from upstream stage
i_valid  in  1  upstream slot holds a real instruction
i_stall  in  1  hold all slices this cycle
i_flush  in  1  squash all slices to NOP this cycle
o_insn  out  INSN_W  instruction from final slice
o_PC_plus  out  PC_W  PC+1 from final slice
o_valid  out  1  valid bit from final slice
o_stall_count  out  CNT_W  number of cycles with i_stall=1 and i_flush=0, saturating

Behaviour:
- Reset (asynchronous, active-high): every slice is set to insn=NOP, PC_plus=0, valid=0. o_stall_count=0. Outputs reflect this immediately, without waiting for a clock edge. While reset is held, clock edges have no effect.
- All registers capture on the falling edge of clock. Inputs are sampled at that edge.
- Slice 0 loads {i_insn, i_PC_plus, i_valid}. Slice k loads slice k-1. Outputs are driven from slice DEPTH-1.
- Latency: an unstalled, unflushed input appears on the outputs after exactly DEPTH falling edges.
- Priority at each falling edge: flush > stall > normal.
  - flush=1: all slices become {NOP, 0, 0}, regardless of stall. The counter does not increment.
  - stall=1, flush=0: all slices hold their value. The counter increments by 1, saturating at 2^CNT_W-1 with no wrap.
  - neither: the shift advances by one slice. The counter holds.
- A flush does not preserve in-flight instructions. A stall releasing the cycle after a flush advances from the bubble state.
- i_valid=0 with normal advance: the payload is still captured unchanged (insn/PC are not forced to NOP). Only flush and reset force NOP.
- o_stall_count is cleared only by reset. There is no software clear.
- DEPTH outside 1..4 is a configuration error: an elaboration-time error is produced via a generate-time check.
- The block is purely registered. Outputs have no combinational path from i_* or i_stall/i_flush.

Test Plan:
- Reset: assert reset mid-cycle with the slices holding insn=32'h1234_5678 -> outputs are immediately {0x00000000, 0, 0} and the counter is 0. Release reset; the first falling edge with i_insn=32'hA, i_PC_plus=12'h005, i_valid=1 gives outputs {0xA, 0x005, 1} (DEPTH=1).
- Latency, DEPTH=3: feed insn values 1,2,3,4 on consecutive falling edges -> o_insn shows NOP, NOP, then 1,2,3,4 starting on the third edge. o_valid rises on the same edge as insn 1.
- Stall: with DEPTH=1 and o_insn=0x11, hold i_stall=1 for 5 edges while i_insn changes -> o_insn stays 0x11 and o_stall_count=5. Drop the stall -> the next edge loads the current i_insn.
- Flush vs stall: assert i_stall=1 and i_flush=1 on the same edge -> all slices are {NOP, 0, 0} and o_stall_count does not increment.
- Saturation: CNT_W=4, stall for 20 edges -> o_stall_count reaches 15 and stays 15.
- Width generality: INSN_W=64, PC_W=20, NOP=64'h13. Flush, then pass insn 64'hDEAD_BEEF_0000_0001 and PC 20'hFFFFF -> after the flush the outputs are 64'h13/0/0, then the passed values appear exactly, with no truncation.
